modport_slave: RTL and testbench

APB (AMBA 3) completer wrapping a single-port word-addressed memory; it forms the APB-side port of the dual-port memory subsystem. It decodes PSEL/PENABLE/PWRITE transfers, inserts a configurable number of wait states, and commits writes to or returns reads from the memory array. The bus signal names match the `apb_if` slave modport, so the block connects directly to it.

---
 rtl/modport_slave.sv | 161 ++++++++++++++++
 tb/tb_modport_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modport_slave.sv
// modport_slave: APB (AMBA 3) completer in front of a single-port,
// word-addressed memory. Bus names follow the apb_if slave modport.
// PRESETn keeps its historical name but is an active-high synchronous reset.
module modport_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);

  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_pready;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                w_state_nxt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_pready_nxt;
  logic                  w_latch;
  logic                  w_rd_load;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_commit;

  // Next-state, next-PREADY and datapath strobes for the transfer FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pready_nxt = r_pready;
    w_latch      = 1'b0;
    w_rd_load    = 1'b0;
    w_rd_addr    = r_addr;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          // Setup phase: capture the request. With no wait states the read
          // data is fetched right now from the live address, which is the
          // same address being latched on this edge.
          w_latch   = 1'b1;
          w_cnt_nxt = WS_LOAD;
          w_rd_addr = PADDR;
          if (WS_LOAD == 4'd0) begin
            w_state_nxt  = S_ACCESS;
            w_pready_nxt = 1'b1;
            w_rd_load    = !PWRITE;
          end else begin
            w_state_nxt  = S_WAIT;
            w_pready_nxt = 1'b0;
          end
        end else begin
          // PENABLE without a preceding setup is ignored.
          w_pready_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          w_state_nxt  = S_IDLE;
          w_pready_nxt = 1'b0;
        end else if (PENABLE) begin
          // The last wait cycle (count of 1, or a defensive 0) opens ACCESS.
          if (r_cnt <= 4'd1) begin
            w_state_nxt  = S_ACCESS;
            w_pready_nxt = 1'b1;
            w_rd_load    = !r_write;
          end else begin
            w_cnt_nxt    = r_cnt - 4'd1;
            w_pready_nxt = 1'b0;
          end
        end else begin
          w_pready_nxt = 1'b0;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          // Abort: drop the transfer without touching memory.
          w_state_nxt  = S_IDLE;
          w_pready_nxt = 1'b0;
        end else if (PENABLE && r_pready) begin
          w_commit     = r_write;
          w_state_nxt  = S_IDLE;
          w_pready_nxt = 1'b0;
        end else begin
          w_pready_nxt = r_pready;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_pready_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter, registered PREADY/PRDATA and the latched request.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_cnt    <= 4'd0;
      r_pready <= 1'b0;
      r_prdata <= {DATA_WIDTH{1'b0}};
      r_addr   <= {ADDR_WIDTH{1'b0}};
      r_write  <= 1'b0;
      r_wdata  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_pready <= w_pready_nxt;
      if (w_latch) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
      end
      if (w_rd_load) begin
        r_prdata <= r_mem[w_rd_addr];
      end
    end
  end

  // Memory array: cleared on reset, written when a write transfer completes.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_commit) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign PRDATA = r_prdata;
  assign PREADY = r_pready;

endmodule

// File: tb/tb_modport_slave.sv
// Self-checking bench for modport_slave. Three instances with different
// wait-state counts share one bus; each has its own PSEL and outputs.
module tb_modport_slave;

  logic             PCLK;
  logic             PRESETn;
  logic [7:0]       PADDR;
  logic             PWRITE;
  logic             PENABLE;
  logic [31:0]      PWDATA;
  logic [2:0]       psel;
  logic [2:0]       pready;
  logic [2:0][31:0] prdata;

  int               n_checks;
  int               n_fail;
  int               cyc;
  logic [31:0]      model [3][256];

  modport_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(psel[0]), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(prdata[0]), .PREADY(pready[0]));

  modport_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(psel[1]), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(prdata[1]), .PREADY(pready[1]));

  modport_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(psel[2]), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(prdata[2]), .PREADY(pready[2]));

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic int ws_of(input int d);
    if (d == 1) return 3;
    if (d == 2) return 2;
    return 0;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++)
        model[d][a] = 32'd0;
  endtask

  task automatic idle();
    psel    = 3'b000;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  // One complete APB transfer on instance d. Starts and ends just after a
  // rising edge; leaves PSEL asserted so the caller may go back to back.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int ncyc, output int nwait);
    int budget;
    bit done;
    ncyc = 0; nwait = 0; rd = 32'd0; done = 1'b0; budget = 0;
    psel    = 3'b000;
    psel[d] = 1'b1;
    PWRITE  = wr; PADDR = a; PWDATA = wd; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    ncyc = 1;
    PENABLE = 1'b1;
    PADDR   = 8'($urandom);
    PWDATA  = $urandom;
    while (!done && budget < 40) begin
      @(negedge PCLK);
      if (pready[d] === 1'b1) begin
        rd   = prdata[d];
        done = 1'b1;
      end else begin
        nwait++;
      end
      @(posedge PCLK); #1;
      ncyc++; budget++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL xfer_timeout inst=%0d: PREADY never rose, required completion", d);
    end else if (wr) begin
      model[d][a] = wd;
    end
    PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int nc, nw;
    PRESETn = 1'b1; psel = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'd0; PWDATA = 32'd0;
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b0;
    clear_model();
    @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (pready[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_pready inst=%0d got %b exp 0", d, pready[d]);
      end
      n_checks++;
      if (prdata[d] !== 32'd0) begin
        n_fail++; $display("FAIL reset_prdata inst=%0d got %h exp 0", d, prdata[d]);
      end
    end
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 8'h00, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL reset_read_00 got %h exp 00000000", rd);
    end
    xfer(0, 1'b0, 8'hFF, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL reset_read_ff got %h exp 00000000", rd);
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int nc, nw;
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, rd, nc, nw);
    n_checks++;
    if (nc !== 2 || nw !== 0) begin
      n_fail++; $display("FAIL wr0_timing got cycles=%0d waits=%0d exp 2/0", nc, nw);
    end
    idle();
    xfer(0, 1'b0, 8'h10, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd0_data got %h exp deadbeef", rd);
    end
    n_checks++;
    if (nc !== 2 || nw !== 0) begin
      n_fail++; $display("FAIL rd0_timing got cycles=%0d waits=%0d exp 2/0", nc, nw);
    end
    psel = 3'b000;
    @(negedge PCLK);
    n_checks++;
    if (pready[0] !== 1'b0) begin
      n_fail++; $display("FAIL rd0_pready_drop got %b exp 0", pready[0]);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int nc, nw;
    xfer(1, 1'b1, 8'h20, 32'h12345678, rd, nc, nw);
    n_checks++;
    if (nc !== 5 || nw !== 3) begin
      n_fail++; $display("FAIL ws3_wr_timing got cycles=%0d waits=%0d exp 5/3", nc, nw);
    end
    idle();
    xfer(1, 1'b0, 8'h20, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== 32'h12345678 || nw !== 3) begin
      n_fail++; $display("FAIL ws3_rd got data=%h waits=%0d exp 12345678/3", rd, nw);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int nc, nw, start;
    logic [31:0] exp_rd;
    start = cyc;
    for (int i = 1; i <= 3; i++)
      xfer(0, 1'b1, 8'(i), 32'(8'hA0 + i), rd, nc, nw);
    for (int i = 3; i >= 1; i--) begin
      exp_rd = 32'(8'hA0 + i);
      xfer(0, 1'b0, 8'(i), 32'd0, rd, nc, nw);
      n_checks++;
      if (rd !== exp_rd) begin
        n_fail++; $display("FAIL b2b_rd addr=%0d got %h exp %h", i, rd, exp_rd);
      end
    end
    n_checks++;
    if (cyc - start !== 12) begin
      n_fail++; $display("FAIL b2b_cycles got %0d exp 12", cyc - start);
    end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd, prior;
    int nc, nw;
    prior = $urandom;
    xfer(2, 1'b1, 8'h30, prior, rd, nc, nw);
    idle();
    psel = 3'b100; PWRITE = 1'b1; PADDR = 8'h30; PWDATA = 32'h55; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    psel = 3'b000; PENABLE = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if (pready[2] !== 1'b0) begin
      n_fail++; $display("FAIL abort_pready got %b exp 0", pready[2]);
    end
    @(posedge PCLK); #1;
    xfer(2, 1'b0, 8'h30, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== model[2][8'h30]) begin
      n_fail++; $display("FAIL abort_rd got %h exp %h", rd, model[2][8'h30]);
    end
    idle();
    // PENABLE high with no setup phase: must never complete.
    psel = 3'b001; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h31; PWDATA = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      n_checks++;
      if (pready[0] !== 1'b0) begin
        n_fail++; $display("FAIL noseup_pready cyc=%0d got %b exp 0", i, pready[0]);
      end
    end
    @(posedge PCLK); #1;
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int nc, nw;
    xfer(0, 1'b1, 8'h10, 32'h0BADCAFE, rd, nc, nw);
    xfer(0, 1'b0, 8'h10, 32'd0, rd, nc, nw);
    psel = 3'b001; PWRITE = 1'b1; PADDR = 8'h40; PWDATA = 32'hFFFFFFFF; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (pready[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_access got %b exp 1", pready[0]);
    end
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0; psel = 3'b000; PENABLE = 1'b0;
    clear_model();
    @(negedge PCLK);
    n_checks++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_out got pready=%b prdata=%h exp 0/0", pready[0], prdata[0]);
    end
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 8'h40, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_rd40 got %h exp 0", rd);
    end
    xfer(0, 1'b0, 8'h10, 32'd0, rd, nc, nw);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_rd10 got %h exp 0", rd);
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd;
    logic [7:0] a;
    int d, nc, nw;
    bit wr;
    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7)) + 8'h80;
      wd = $urandom;
      exp_rd = model[d][a];
      xfer(d, wr, a, wd, rd, nc, nw);
      n_checks++;
      if (nc !== 2 + ws_of(d) || nw !== ws_of(d)) begin
        n_fail++; $display("FAIL rand_timing i=%0d inst=%0d got %0d/%0d exp %0d/%0d",
                           i, d, nc, nw, 2 + ws_of(d), ws_of(d));
      end
      if (!wr) begin
        n_checks++;
        if (rd !== exp_rd) begin
          n_fail++; $display("FAIL rand_rd i=%0d inst=%0d addr=%h got %h exp %h",
                             i, d, a, rd, exp_rd);
        end
      end
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    psel = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd0; PWDATA = 32'd0;
    PRESETn = 1'b1;
    test_reset();
    test_write_read();
    test_wait_states();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
